rr_grant_arbiter: RTL and testbench

//   Shares one resource among NREQ requesters with round-robin priority.

---
 rtl/arb_pkg.sv | 10 +
 rtl/rr_priority_pick.sv | 30 +++
 rtl/rr_grant_arbiter.sv | 103 ++++++++++
 tb/tb_rr_grant_arbiter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types for the round-robin grant arbiter: FSM state encodings.
package arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_GRANT = 2'b01,
    ARB_COOL  = 2'b10
  } arb_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating priority encoder: first set req bit at ptr, ptr+1, ... with wrap.
module rr_priority_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  pick,
  output logic            any_req
);

  logic found;
  int   idx;

  always_comb begin
    pick    = '0;
    any_req = |req;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        pick  = IDW'(idx);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with registered one-hot grant, release cooldown of GAP cycles and,
// with ARB_TIMEOUT_EN defined, a forced release after MAX_HOLD grant cycles.
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int GAP      = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_valid,
  output logic [IDW-1:0]  gnt_id,
  output logic            busy,
  output logic            timeout_evt
);

  if (IDW != $clog2(NREQ) || MAX_HOLD < 1 || GAP > 15) begin : g_cfg_err
    $error("rr_grant_arbiter: bad parameter set");
  end

  arb_state_t     state, state_d;
  logic [IDW-1:0] ptr, pick;
  logic           any_req, owner_rel, timeout_now;
  logic [3:0]     gap_cnt;

  rr_priority_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .pick    (pick),
    .any_req (any_req)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold;

  assign timeout_now = (state == ARB_GRANT) && (hold == HW'(MAX_HOLD - 1));

  // hold counts completed GRANT cycles; it sits at zero outside GRANT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold        <= '0;
      timeout_evt <= 1'b0;
    end else begin
      timeout_evt <= timeout_now;
      if (state == ARB_GRANT && !owner_rel) hold <= hold + 1'b1;
      else                                  hold <= '0;
    end
  end
`else
  assign timeout_now = 1'b0;
  assign timeout_evt = 1'b0;
`endif

  assign owner_rel = done || !req[gnt_id] || timeout_now;

  always_comb begin
    state_d = state;
    case (state)
      ARB_IDLE:  if (any_req) state_d = ARB_GRANT;
      ARB_GRANT: if (owner_rel) state_d = (GAP > 0) ? ARB_COOL : ARB_IDLE;
      ARB_COOL:  if (int'(gap_cnt) + 1 >= GAP) state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB_IDLE;
      ptr       <= '0;
      gap_cnt   <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      busy      <= 1'b0;
    end else begin
      state <= state_d;
      busy  <= (state_d != ARB_IDLE);
      case (state)
        ARB_IDLE: if (any_req) begin
          gnt       <= NREQ'(1) << pick;
          gnt_valid <= 1'b1;
          gnt_id    <= pick;
        end
        ARB_GRANT: if (owner_rel) begin
          gnt       <= '0;
          gnt_valid <= 1'b0;
          gap_cnt   <= '0;
          // priority moves just past the releasing owner
          ptr       <= (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;
        end
        ARB_COOL: gap_cnt <= gap_cnt + 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter (NREQ=4, GAP=1, MAX_HOLD=8); honours ARB_TIMEOUT_EN.
module tb_rr_grant_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout_evt;

  int checks = 0;
  int errors = 0;

  rr_grant_arbiter #(.NREQ(4), .IDW(2), .GAP(1), .MAX_HOLD(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .gnt         (gnt),
    .gnt_valid   (gnt_valid),
    .gnt_id      (gnt_id),
    .busy        (busy),
    .timeout_evt (timeout_evt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_gnt",   32'(gnt), 32'h0);
    chk("reset_valid", 32'(gnt_valid), 32'h0);
    chk("reset_id",    32'(gnt_id), 32'h0);
    chk("reset_busy",  32'(busy), 32'h0);
    chk("reset_tevt",  32'(timeout_evt), 32'h0);

    // single requester, done release, one cooldown cycle
    req = 4'b0100;
    tick();
    chk("t2_gnt",   32'(gnt), 32'h4);
    chk("t2_id",    32'(gnt_id), 32'h2);
    chk("t2_valid", 32'(gnt_valid), 32'h1);
    chk("t2_busy",  32'(busy), 32'h1);
    tick();
    chk("t2_hold", 32'(gnt), 32'h4);
    done = 1'b1;
    tick();
    done = 1'b0; req = 4'b0000;
    chk("t2_rel_gnt",   32'(gnt), 32'h0);
    chk("t2_rel_valid", 32'(gnt_valid), 32'h0);
    chk("t2_cool_busy", 32'(busy), 32'h1);
    chk("t2_id_kept",   32'(gnt_id), 32'h2);
    tick();
    chk("t2_idle_busy", 32'(busy), 32'h0);

    // all requesting: rotation 0,1,2,3 then wrap to 0
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t3_gnt",  32'(gnt), 32'(1 << k));
      chk("t3_id",   32'(gnt_id), 32'(k));
      tick();
      chk("t3_hold", 32'(gnt), 32'(1 << k));
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("t3_rel", 32'(gnt), 32'h0);
      if (k == 3) req = 4'b1001;
      tick();
      chk("t3_idle", 32'(busy), 32'h0);
    end
    tick();
    chk("t4_wrap_gnt", 32'(gnt), 32'h1);
    chk("t4_wrap_id",  32'(gnt_id), 32'h0);

    // done coincident with new request: release wins, req 1 granted after GAP
    done = 1'b1; req = 4'b1011;
    tick();
    done = 1'b0; req = 4'b0011;
    chk("t5_rel_gnt",  32'(gnt), 32'h0);
    chk("t5_rel_busy", 32'(busy), 32'h1);
    tick();
    chk("t5_cool_gnt", 32'(gnt), 32'h0);
    chk("t5_idle",     32'(busy), 32'h0);
    tick();
    chk("t5_gnt", 32'(gnt), 32'h2);
    chk("t5_id",  32'(gnt_id), 32'h1);

    // async reset mid-grant takes effect before the next edge
    #2 rst = 1'b1;
    #1;
    chk("t1_gnt",   32'(gnt), 32'h0);
    chk("t1_valid", 32'(gnt_valid), 32'h0);
    chk("t1_busy",  32'(busy), 32'h0);
    chk("t1_id",    32'(gnt_id), 32'h0);
    #1 rst = 1'b0; req = 4'b0010;
    tick();
    chk("drop_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    tick();
    chk("drop_rel",  32'(gnt), 32'h0);
    chk("drop_busy", 32'(busy), 32'h1);
    tick();
    chk("drop_idle", 32'(busy), 32'h0);

    // long hold by owner 3 while 0 waits; no preemption
    req = 4'b1000;
    tick();
    chk("t6_gnt", 32'(gnt), 32'h8);
    chk("t6_id",  32'(gnt_id), 32'h3);
    req = 4'b1001;
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("t6_hold", 32'(gnt), 32'h8);
      chk("t6_tevt", 32'(timeout_evt), 32'h0);
    end
    tick();
`ifdef ARB_TIMEOUT_EN
    chk("t6_to_gnt",  32'(gnt), 32'h0);
    chk("t6_to_tevt", 32'(timeout_evt), 32'h1);
    tick();
    chk("t6_tevt_off", 32'(timeout_evt), 32'h0);
    chk("t6_idle",     32'(busy), 32'h0);
    tick();
    chk("t6_next_gnt", 32'(gnt), 32'h1);
    chk("t6_next_id",  32'(gnt_id), 32'h0);
`else
    chk("t6_stay_gnt",  32'(gnt), 32'h8);
    chk("t6_stay_tevt", 32'(timeout_evt), 32'h0);
    tick(); tick(); tick();
    chk("t6_stay_long", 32'(gnt), 32'h8);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("t6_rel_gnt", 32'(gnt), 32'h0);
    tick(); tick();
    chk("t6_next_gnt", 32'(gnt), 32'h1);
    chk("t6_next_id",  32'(gnt_id), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
